// File: rtl/aes_cipher_out_serializer.sv
// Output serializer for the AES pipeline: buffers whole cipher blocks in a small
// FIFO and streams each one out MSB-word first over a valid/ready handshake.
module aes_cipher_out_serializer #(
  parameter int DATA_LEN   = 128,
  parameter int WORD_LEN   = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               data_valid_in,
  input  logic [DATA_LEN-1:0]                cipher_text,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [WORD_LEN-1:0]                out_word,
  output logic                               out_last,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level,
  output logic                               overflow
);

  localparam int NUM_WORDS = DATA_LEN / WORD_LEN;
  localparam int PTR_W     = $clog2(FIFO_DEPTH);
  localparam int LVL_W     = $clog2(FIFO_DEPTH + 1);
  localparam int CNT_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);
  localparam logic [LVL_W-1:0] LVL_ZERO = {LVL_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_WORDS - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  logic [DATA_LEN-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_LEN-1:0] mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]    level_q, level_d;
  logic                overflow_q, overflow_d;
  logic [0:0]          state_q, state_d;
  logic [DATA_LEN-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                out_valid_q, out_valid_d;
  logic [WORD_LEN-1:0] out_word_q, out_word_d;
  logic                out_last_q, out_last_d;

  logic xfer_s;
  logic last_s;
  logic pop_s;
  logic push_s;

  // Handshake decode; a pop frees a slot, so a push on a full FIFO still lands
  always_comb begin
    xfer_s = (state_q == ST_SEND) && out_ready;
    last_s = (cnt_q == CNT_LAST);
    pop_s  = (level_q != LVL_ZERO) && ((state_q == ST_IDLE) || (xfer_s && last_s));
    push_s = data_valid_in && ((level_q != LVL_FULL) || pop_s);
  end

  // FIFO storage, pointers, occupancy and sticky drop flag
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_s) begin
      mem_d[wr_ptr_q] = cipher_text;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
    overflow_d = overflow_q | (data_valid_in & ~push_s);
  end

  // Sender FSM and word shifter; the shifter always presents its top word
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (pop_s) begin
          state_d = ST_SEND;
          shift_d = mem_q[rd_ptr_q];
          cnt_d   = CNT_ZERO;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (xfer_s && !last_s) begin
          cnt_d   = cnt_q + CNT_W'(1);
          shift_d = shift_q << WORD_LEN;
        end else if (xfer_s && pop_s) begin
          shift_d = mem_q[rd_ptr_q];
          cnt_d   = CNT_ZERO;
        end else if (xfer_s) begin
          state_d = ST_IDLE;
          cnt_d   = CNT_ZERO;
        end else begin
          state_d = ST_SEND;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // Output register inputs derived from the next state so outputs stay flopped
  always_comb begin
    out_valid_d = (state_d == ST_SEND);
    if (out_valid_d) begin
      out_word_d = shift_d[DATA_LEN-1 -: WORD_LEN];
      out_last_d = (cnt_d == CNT_LAST);
    end else begin
      out_word_d = {WORD_LEN{1'b0}};
      out_last_d = 1'b0;
    end
  end

  // State registers; reset drops queued and in-flight blocks at once
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= {DATA_LEN{1'b0}};
      end
      wr_ptr_q    <= {PTR_W{1'b0}};
      rd_ptr_q    <= {PTR_W{1'b0}};
      level_q     <= LVL_ZERO;
      overflow_q  <= 1'b0;
      state_q     <= ST_IDLE;
      shift_q     <= {DATA_LEN{1'b0}};
      cnt_q       <= CNT_ZERO;
      out_valid_q <= 1'b0;
      out_word_q  <= {WORD_LEN{1'b0}};
      out_last_q  <= 1'b0;
    end else begin
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      overflow_q  <= overflow_d;
      state_q     <= state_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_word_q  <= out_word_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_word   = out_word_q;
  assign out_last   = out_last_q;
  assign fifo_level = level_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_aes_cipher_out_serializer.sv
// Directed bench for aes_cipher_out_serializer with a word scoreboard.
module tb_aes_cipher_out_serializer;

  logic         clk = 1'b0;
  logic         reset;
  logic         data_valid_in;
  logic [127:0] cipher_text;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_word;
  logic         out_last;
  logic [2:0]   fifo_level;
  logic         overflow;

  int total = 0;
  int bad   = 0;

  logic [32:0] sbq[$];

  logic        hold_prev = 1'b0;
  logic [31:0] word_prev;
  logic        last_prev;

  aes_cipher_out_serializer dut (
    .clk(clk), .reset(reset), .data_valid_in(data_valid_in), .cipher_text(cipher_text),
    .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word), .out_last(out_last),
    .fifo_level(fifo_level), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one block for one edge; optionally queue its four words as expected output.
  task automatic cap(input logic [127:0] b, input bit expect_out);
    data_valid_in = 1'b1;
    cipher_text   = b;
    if (expect_out) begin
      for (int w = 0; w < 4; w++) begin
        logic [31:0] wd;
        wd = b[127 - 32*w -: 32];
        sbq.push_back({(w == 3), wd});
      end
    end
    step();
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (sbq.size() != 0 && n < 500) begin
      step();
      n++;
    end
    chk(tag, 128'(sbq.size()), 128'd0);
  endtask

  function automatic logic [127:0] rnd_blk();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Scoreboard and hold-stability monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (reset !== 1'b1) begin
      hold_prev <= 1'b0;
    end else begin
      if (hold_prev) begin
        chk("hold_valid", 128'(out_valid), 128'd1);
        chk("hold_word", 128'(out_word), 128'(word_prev));
        chk("hold_last", 128'(out_last), 128'(last_prev));
      end
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          chk("unexpected_word", 128'(out_word), 128'hDEAD_0000_0000);
        end else begin
          logic [32:0] e;
          e = sbq.pop_front();
          chk("sb_word", 128'(out_word), 128'(e[31:0]));
          chk("sb_last", 128'(out_last), 128'(e[32]));
        end
      end
      hold_prev <= out_valid && !out_ready;
      word_prev <= out_word;
      last_prev <= out_last;
    end
  end

  initial begin
    logic [127:0] k;
    logic [127:0] b;
    k = 128'h3925841d02dc09fbdc118597196a0b32;
    reset = 1'b0; data_valid_in = 1'b0; cipher_text = 128'd0; out_ready = 1'b0;
    step(); step();
    chk("rst_valid", 128'(out_valid), 128'd0);
    chk("rst_word", 128'(out_word), 128'd0);
    chk("rst_last", 128'(out_last), 128'd0);
    chk("rst_level", 128'(fifo_level), 128'd0);
    chk("rst_ovf", 128'(overflow), 128'd0);
    reset = 1'b1;
    step();

    // single block, latency
    out_ready = 1'b1;
    cap(k, 1'b1);
    data_valid_in = 1'b0;
    chk("single_level1", 128'(fifo_level), 128'd1);
    chk("single_novalid", 128'(out_valid), 128'd0);
    step();
    chk("single_valid", 128'(out_valid), 128'd1);
    chk("single_w0", 128'(out_word), 128'h3925841d);
    chk("single_level0", 128'(fifo_level), 128'd0);
    drain("single_drain");
    chk("single_idle", 128'(out_valid), 128'd0);
    step();

    // backpressure on word 1
    cap(k, 1'b1);
    data_valid_in = 1'b0;
    step();
    step();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("bp_word1", 128'(out_word), 128'h02dc09fb);
      chk("bp_valid", 128'(out_valid), 128'd1);
      step();
    end
    out_ready = 1'b1;
    drain("bp_drain");
    chk("bp_idle", 128'(out_valid), 128'd0);
    step();

    // back-to-back, zero bubble
    cap(rnd_blk(), 1'b1);
    cap(rnd_blk(), 1'b1);
    data_valid_in = 1'b0;
    chk("b2b_level1", 128'(fifo_level), 128'd1);
    for (int i = 0; i < 8; i++) begin
      chk("b2b_valid", 128'(out_valid), 128'd1);
      if (i == 4) chk("b2b_level0", 128'(fifo_level), 128'd0);
      step();
    end
    chk("b2b_idle", 128'(out_valid), 128'd0);
    chk("b2b_empty", 128'(sbq.size()), 128'd0);
    step();

    // overflow: six blocks with consumer stalled
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cap(rnd_blk(), (i < 5));
      if (i == 3) chk("ovf_level3", 128'(fifo_level), 128'd3);
      if (i == 4) begin
        chk("ovf_level4", 128'(fifo_level), 128'd4);
        chk("ovf_not_yet", 128'(overflow), 128'd0);
      end
    end
    data_valid_in = 1'b0;
    chk("ovf_full", 128'(fifo_level), 128'd4);
    chk("ovf_set", 128'(overflow), 128'd1);
    out_ready = 1'b1;
    drain("ovf_drain");
    chk("ovf_sticky", 128'(overflow), 128'd1);
    chk("ovf_level_end", 128'(fifo_level), 128'd0);
    step();

    // reset during word 2 with two blocks queued
    b = rnd_blk();
    sbq.push_back({1'b0, b[127:96]});
    sbq.push_back({1'b0, b[95:64]});
    cap(b, 1'b0);
    cap(rnd_blk(), 1'b0);
    cap(rnd_blk(), 1'b0);
    data_valid_in = 1'b0;
    chk("rmt_level2", 128'(fifo_level), 128'd2);
    step();
    chk("rmt_word2", 128'(out_word), 128'(b[63:32]));
    reset = 1'b0;
    #1;
    chk("rmt_valid", 128'(out_valid), 128'd0);
    chk("rmt_word", 128'(out_word), 128'd0);
    chk("rmt_level", 128'(fifo_level), 128'd0);
    chk("rmt_ovf", 128'(overflow), 128'd0);
    chk("rmt_sb", 128'(sbq.size()), 128'd0);
    step(); step();
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("rmt_nostale", 128'(out_valid), 128'd0);
    end
    cap(rnd_blk(), 1'b1);
    data_valid_in = 1'b0;
    drain("rmt_new_drain");
    step();

    // full FIFO, push coinciding with last-word pop
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) cap(rnd_blk(), 1'b1);
    data_valid_in = 1'b0;
    chk("sim_full", 128'(fifo_level), 128'd4);
    out_ready = 1'b1;
    step(); step(); step();
    chk("sim_last", 128'(out_last), 128'd1);
    cap(rnd_blk(), 1'b1);
    data_valid_in = 1'b0;
    chk("sim_level", 128'(fifo_level), 128'd4);
    chk("sim_ovf", 128'(overflow), 128'd0);
    drain("sim_drain");
    chk("sim_level_end", 128'(fifo_level), 128'd0);
    chk("sim_ovf_end", 128'(overflow), 128'd0);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
